mem_arbiter: RTL
================

# mem_arbiter

- Shares one single-port, variable-latency memory between the pipeline's instruction-fetch port (PCF/InstrF) and its data port (ALUResultM/WriteDataM/ReadDataM/MemWriteM).
- Data accesses take priority over fetches.
- Raises `stall_mem` to freeze the whole pipeline, alongside the hazard unit's StallF/StallD, until every access requested this cycle has completed.
- Sits between the pipeline core and the memory system.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, maximum wait cycles for `mem_ready` before the access is aborted
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-low reset (0 = reset)
- `if_req` in 1, fetch request (tie high during normal run)
- `if_addr` in AW, fetch address (PCF)
- `if_rdata` out DW, fetched instruction (InstrF)
- `if_ready` out 1, fetch complete; stays high until the pipeline advances
- `d_req` in 1, load or store present in the M stage
- `d_we` in 1, store (MemWriteM)
- `d_addr` in AW, data address (ALUResultM)
- `d_wdata` in DW, store data (WriteDataM)
- `d_rdata` out DW, load data (ReadDataM)
- `d_ready` out 1, data access complete; stays high until the pipeline advances
- `mem_req`, `mem_we` out 1, memory request and write enable
- `mem_addr` out AW, memory address
- `mem_wdata` out DW, memory write data
- `mem_rdata` in DW, memory read data
- `mem_ready` in 1, memory completes the access this cycle
- `stall_mem` out 1, pipeline freeze
- `err_timeout` out 1, sticky; set on any aborted access

## Operation
- FSM states: IDLE, D_BUSY, I_BUSY.
- IDLE:
  - `d_req & ~d_done` → latch `d_addr`/`d_we`/`d_wdata` into the `mem_*` registers and go to D_BUSY.
  - Otherwise `if_req & ~i_done` → latch `if_addr` (`mem_we`=0) and go to I_BUSY.
- D_BUSY / I_BUSY:
  - `mem_req`=1; `mem_addr`, `mem_we` and `mem_wdata` held stable.
  - On `mem_ready`: capture `mem_rdata` into `d_rdata` or `if_rdata`, and set `d_done` or `i_done`.
  - From D_BUSY: if `if_req & ~i_done`, go straight to I_BUSY and issue the fetch next cycle; otherwise go to IDLE.
  - From I_BUSY: go to IDLE.
- Readiness and stall:
  - `d_ready` = `d_done`; `if_ready` = `i_done`.
  - `stall_mem` = (`d_req` & ~`d_done`) | (`if_req` & ~`i_done`).
  - When `stall_mem` is 0 at a rising edge, the pipeline advances: clear `d_done` and `i_done`.
- Loads: `d_rdata` holds its value until the next data completion. On stores, `d_rdata` is unchanged.
- Timeout:
  - Wait counter `wcnt` (8 bits minimum, must hold `TIMEOUT`) resets on every entry to a BUSY state.
  - When `wcnt` = `TIMEOUT` without `mem_ready`: drop `mem_req`, set `err_timeout`, and complete the access with substitute data (fetch `if_rdata` = 32'h00000013 NOP; load `d_rdata` = 0; store discarded).
  - `err_timeout` clears only on reset.
- `mem_ready` is ignored in IDLE.

## Timing
- Every output is registered except `stall_mem`, which is combinational from `d_req`/`if_req` and the done flags.
- Reset values: FSM = IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0; `if_rdata`=32'h00000013; `d_rdata`=0; done flags = 0; `err_timeout`=0; `wcnt`=0.
- Single access:
  - Request seen at edge n; `mem_req` high from n+1.
  - `mem_ready` seen at edge n+1+k (k ≥ 0 wait cycles); done flag high from n+2+k.
  - Stall spans k+2 cycles.
- Simultaneous data and fetch:
  - Fetch `mem_req` rises on the cycle after `mem_ready` for the data access.
  - Total stall = kd + ki + 4 cycles.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronous) and the in-flight access is abandoned. The memory side must tolerate an unmatched request.
- Requests are sampled only in IDLE or at the D_BUSY→I_BUSY transition. Changes to `d_addr`/`if_addr` during BUSY are ignored; the pipeline is stalled, so these inputs are stable anyway.

## Configuration
- `MEMARB_IBUF_EN` defined:
  - Adds a single-entry fetch buffer (`ibuf_addr`, `ibuf_data`, `ibuf_v`).
  - In IDLE, a fetch with `ibuf_v` & `ibuf_addr`==`if_addr` sets `i_done` with `if_rdata`=`ibuf_data` on the next edge, with no memory access (1-cycle stall).
  - Each completed memory fetch loads the buffer.
  - A store completing to `ibuf_addr` clears `ibuf_v`.
  - Reset and timeout clear `ibuf_v`.
- `MEMARB_IBUF_EN` undefined: no buffer; every fetch goes to memory.

## Structure
- `memarb_pkg` holds:
  - FSM state enum (IDLE=2'd0, D_BUSY=2'd1, I_BUSY=2'd2)
  - `MEMARB_NOP` = 32'h00000013
  - timeout counter width constant
- Sub-module `memarb_ibuf` holds the fetch buffer and hit logic. It is instantiated only under `MEMARB_IBUF_EN`.

## Test plan
- Fetch only, `mem_ready` after k=2: `if_addr`=0x40 → `mem_req` high for 3 cycles, `if_rdata`=`mem_rdata` (0x00A00093), `stall_mem` high for 4 cycles.
- Load and fetch in the same cycle: `d_addr`=0x100, `if_addr`=0x44, k=0 each → data served first, fetch `mem_req` rises the cycle after the data `mem_ready`, `stall_mem` high for 4 cycles, `d_rdata` and `if_rdata` both correct.
- Store: `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF → `mem_we`=1, `mem_addr`=0x200, `mem_wdata`=0xDEADBEEF held until `mem_ready`; `d_rdata` unchanged.
- Timeout: `TIMEOUT`=4, `mem_ready` never asserted on a fetch → `mem_req` drops after 4 wait cycles, `err_timeout`=1 sticky, `if_rdata`=0x00000013, pipeline released.
- Reset: assert `reset`=0 during D_BUSY → `mem_req`=0 within the same cycle, all outputs at reset values, no `d_ready` pulse after release.
- With `MEMARB_IBUF_EN`: fetch 0x80 twice → second fetch has no `mem_req` and 1-cycle stall; then a store to 0x80 followed by a fetch of 0x80 → fetch goes to memory.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arbState_e;

    localparam logic [31:0] MEMARB_NOP = 32'h00000013;
    localparam int unsigned WCNT_W     = 8;

endpackage

// File: rtl/memarb_ibuf.sv
// Single-entry fetch buffer: remembers the last memory fetch so a repeated
// fetch of the same address can complete without a memory access.
module memarb_ibuf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fill,
    input  logic [AW-1:0] fillAddr,
    input  logic [DW-1:0] fillData,
    input  logic          inval,
    input  logic [AW-1:0] invalAddr,
    input  logic          clr,
    input  logic [AW-1:0] lookupAddr,
    output logic          hit_c,
    output logic [DW-1:0] hitData
);

    logic [AW-1:0] ibuf_addr;
    logic          ibuf_v;

    // A store to the buffered address makes the cached instruction stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibuf_v    <= 1'b0;
            ibuf_addr <= '0;
            hitData   <= '0;
        end else if (clr) begin
            ibuf_v <= 1'b0;
        end else if (fill) begin
            ibuf_v    <= 1'b1;
            ibuf_addr <= fillAddr;
            hitData   <= fillData;
        end else if (inval && (invalAddr == ibuf_addr)) begin
            ibuf_v <= 1'b0;
        end
    end

    assign hit_c = ibuf_v & (ibuf_addr == lookupAddr);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory between the fetch and data ports,
// data first. Define MEMARB_IBUF_EN to add a single-entry fetch buffer.
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_mem,
    output logic          err_timeout
);

    localparam int unsigned ToBits = $clog2(TIMEOUT + 1);
    localparam int unsigned CntW   = (ToBits > WCNT_W) ? ToBits : WCNT_W;

    arbState_e     state, stateNext;
    logic          d_done, i_done, dDoneNext, iDoneNext;
    logic [CntW-1:0] wcnt, wcntNext;
    logic          memReqNext, memWeNext, errNext;
    logic [AW-1:0] memAddrNext;
    logic [DW-1:0] memWdataNext, dRdataNext, ifRdataNext;
    logic          dPending, iPending, accDone, accAbort;
    logic          ibufHit;
    logic [DW-1:0] ibufData;

    assign dPending  = d_req & ~d_done;
    assign iPending  = if_req & ~i_done;
    assign stall_mem = dPending | iPending;
    assign d_ready   = d_done;
    assign if_ready  = i_done;

    // mem_req is only ever high in a BUSY state, so this also ignores mem_ready in IDLE.
    assign accDone  = mem_req & mem_ready;
    assign accAbort = mem_req & ~mem_ready & (wcnt == CntW'(TIMEOUT));

`ifdef MEMARB_IBUF_EN
    memarb_ibuf #(.AW(AW), .DW(DW)) uIbuf (
        .clk        (clk),
        .reset      (reset),
        .fill       ((state == I_BUSY) && accDone),
        .fillAddr   (mem_addr),
        .fillData   (mem_rdata),
        .inval      ((state == D_BUSY) && accDone && mem_we),
        .invalAddr  (mem_addr),
        .clr        (accAbort),
        .lookupAddr (if_addr),
        .hit_c      (ibufHit),
        .hitData    (ibufData)
    );
`else
    assign ibufHit  = 1'b0;
    assign ibufData = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= DW'(MEMARB_NOP);
            d_rdata     <= '0;
            d_done      <= 1'b0;
            i_done      <= 1'b0;
            err_timeout <= 1'b0;
            wcnt        <= '0;
        end else begin
            state       <= stateNext;
            mem_req     <= memReqNext;
            mem_we      <= memWeNext;
            mem_addr    <= memAddrNext;
            mem_wdata   <= memWdataNext;
            if_rdata    <= ifRdataNext;
            d_rdata     <= dRdataNext;
            d_done      <= dDoneNext;
            i_done      <= iDoneNext;
            err_timeout <= errNext;
            wcnt        <= wcntNext;
        end
    end

    // Done flags drop when the pipeline advances; a completion this edge overrides that.
    always_comb begin
        stateNext    = state;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        dRdataNext   = d_rdata;
        ifRdataNext  = if_rdata;
        dDoneNext    = d_done & stall_mem;
        iDoneNext    = i_done & stall_mem;
        wcntNext     = wcnt;
        errNext      = err_timeout | accAbort;

        case (state)
            IDLE: begin
                if (dPending) begin
                    stateNext    = D_BUSY;
                    memReqNext   = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    wcntNext     = '0;
                end else if (iPending) begin
                    if (ibufHit) begin
                        iDoneNext   = 1'b1;
                        ifRdataNext = ibufData;
                    end else begin
                        stateNext   = I_BUSY;
                        memReqNext  = 1'b1;
                        memWeNext   = 1'b0;
                        memAddrNext = if_addr;
                        wcntNext    = '0;
                    end
                end
            end
            D_BUSY: begin
                if (accDone || accAbort) begin
                    dDoneNext  = 1'b1;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    if (!mem_we) begin
                        dRdataNext = accAbort ? '0 : mem_rdata;
                    end
                    // The pending fetch address is latched now; its request goes out next cycle.
                    if (iPending) begin
                        stateNext   = I_BUSY;
                        memAddrNext = if_addr;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    wcntNext = CntW'(wcnt + 1'b1);
                end
            end
            I_BUSY: begin
                if (!mem_req) begin
                    memReqNext = 1'b1;
                    wcntNext   = '0;
                end else if (accDone || accAbort) begin
                    iDoneNext   = 1'b1;
                    memReqNext  = 1'b0;
                    ifRdataNext = accAbort ? DW'(MEMARB_NOP) : mem_rdata;
                    stateNext   = IDLE;
                end else begin
                    wcntNext = CntW'(wcnt + 1'b1);
                end
            end
            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
    end

endmodule
